// File: rtl/op_decode_stage.sv
// op_decode_stage
//   Registered instruction-decode stage for a TIS node core. Splits the
//   instruction word {op[3:0], src[2:0], const[DATA_W-1:0], dst[2:0]} into
//   control fields and resolves the source operand, stalling on blocking
//   neighbour-port reads (fixed port, ANY, LAST).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_instr/in_valid     instruction from fetch; in_ready = stage can accept
//   port_data/port_valid  neighbour words, port i at [i*DATA_W +: DATA_W]
//   port_ack              one-cycle pulse when a neighbour word is consumed
//   out_valid/out_ready   decoded bundle handshake towards execute
//   pc_instr              opcode passthrough
//   alu_instr             0 none, 1 ADD, 2 SUB, 3 NEG
//   registers_instr       0 none, 1 WRITE, 2 SWP, 3 SAV
//   in_mux_sel            0 CONST, 1 ACC, 2 DIR
//   out_mux_sel           0 ALU, 1 IN
//   operand               resolved source value (signed, DATA_W bits)
//   dst                   destination target passthrough
//
// Opcodes: NOP=0 MOV=1 SWP=2 SAV=3 ADD=4 SUB=5 NEG=6 JMP=7 JEZ=8 JNZ=9
//          JGZ=10 JLZ=11 JRO=12
// Sources: NIL=0 ACC=1 port i=2+i ANY=6 LAST=7

module op_decode_stage #(
    parameter int DATA_W    = 11,
    parameter int NUM_PORTS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W+9:0]             in_instr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_PORTS*DATA_W-1:0]   port_data,
    input  logic [NUM_PORTS-1:0]          port_valid,
    output logic [NUM_PORTS-1:0]          port_ack,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [3:0]                    pc_instr,
    output logic [1:0]                    alu_instr,
    output logic [1:0]                    registers_instr,
    output logic [1:0]                    in_mux_sel,
    output logic                          out_mux_sel,
    output logic signed [DATA_W-1:0]      operand,
    output logic [2:0]                    dst
);

    localparam int IW = DATA_W + 10;

    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_SWP = 4'd2;
    localparam logic [3:0] OP_SAV = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_NEG = 4'd6;

    localparam logic [2:0] SRC_NIL  = 3'd0;
    localparam logic [2:0] SRC_ACC  = 3'd1;
    localparam logic [2:0] SRC_P0   = 3'd2;
    localparam logic [2:0] SRC_ANY  = 3'd6;
    localparam logic [2:0] SRC_LAST = 3'd7;
    localparam logic [2:0] PORT_END = 3'(2 + NUM_PORTS);

    localparam logic [1:0] IN_CONST = 2'd0;
    localparam logic [1:0] IN_ACC   = 2'd1;
    localparam logic [1:0] IN_DIR   = 2'd2;

    typedef enum logic [1:0] {ST_EMPTY, ST_READ, ST_FULL} state_t;

    function automatic logic [1:0] dec_alu(input logic [3:0] op);
        case (op)
            OP_ADD:  dec_alu = 2'd1;
            OP_SUB:  dec_alu = 2'd2;
            OP_NEG:  dec_alu = 2'd3;
            default: dec_alu = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] dec_regs(input logic [3:0] op);
        case (op)
            OP_MOV, OP_ADD, OP_SUB, OP_NEG: dec_regs = 2'd1;
            OP_SWP:  dec_regs = 2'd2;
            OP_SAV:  dec_regs = 2'd3;
            default: dec_regs = 2'd0;
        endcase
    endfunction

    // Field split
    logic [3:0]               f_op;
    logic [2:0]               f_src;
    logic signed [DATA_W-1:0] f_const;
    logic [2:0]               f_dst;

    assign f_op    = in_instr[IW-1 -: 4];
    assign f_src   = in_instr[IW-5 -: 3];
    assign f_const = in_instr[DATA_W+2:3];
    assign f_dst   = in_instr[2:0];

    // State
    state_t                   state_q, state_d;
    logic [2:0]               src_q, src_d;
    logic [1:0]               last_port_q, last_port_d;
    logic [3:0]               pc_q, pc_d;
    logic [1:0]               alu_q, alu_d;
    logic [1:0]               regs_q, regs_d;
    logic [1:0]               in_mux_q, in_mux_d;
    logic                     out_mux_q, out_mux_d;
    logic signed [DATA_W-1:0] operand_q, operand_d;
    logic [2:0]               dst_q, dst_d;

    // Ports padded to four so every port index is in range whatever NUM_PORTS is;
    // the padding reads as never-valid.
    logic [3:0]          pvalid_ext;
    logic [4*DATA_W-1:0] pdata_ext;
    logic [3:0]          ack_ext;

    always_comb begin
        pvalid_ext = '0;
        pdata_ext  = '0;
        pvalid_ext[NUM_PORTS-1:0]        = port_valid;
        pdata_ext[NUM_PORTS*DATA_W-1:0]  = port_data;
    end

    // Port selection for the pending read
    logic [1:0]        rd_idx;
    logic              rd_hit;
    logic              rd_fire;
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        rd_idx = 2'd0;
        rd_hit = 1'b0;
        case (src_q)
            SRC_ANY: begin
                // Descending scan so the lowest valid index wins.
                for (int i = 3; i >= 0; i--) begin
                    if (pvalid_ext[i]) begin
                        rd_idx = 2'(i);
                        rd_hit = 1'b1;
                    end
                end
            end
            SRC_LAST: begin
                rd_idx = last_port_q;
                rd_hit = pvalid_ext[last_port_q];
            end
            default: begin
                rd_idx = src_q[1:0] - 2'd2;
                rd_hit = pvalid_ext[rd_idx];
            end
        endcase
    end

    assign rd_fire  = (state_q == ST_READ) && rd_hit;
    assign rd_word  = pdata_ext[rd_idx*DATA_W +: DATA_W];
    assign ack_ext  = rd_fire ? (4'b0001 << rd_idx) : 4'b0000;
    assign port_ack = ack_ext[NUM_PORTS-1:0];

    assign in_ready = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready);

    logic accept;
    logic src_is_port;
    logic src_is_nil;

    assign accept      = in_valid && in_ready;
    assign src_is_port = ((f_src >= SRC_P0) && (f_src < PORT_END)) ||
                         (f_src == SRC_ANY) || (f_src == SRC_LAST);
    // Out-of-range port codes collapse onto NIL.
    assign src_is_nil  = !src_is_port && (f_src != SRC_ACC);

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        last_port_d = last_port_q;
        pc_d        = pc_q;
        alu_d       = alu_q;
        regs_d      = regs_q;
        in_mux_d    = in_mux_q;
        out_mux_d   = out_mux_q;
        operand_d   = operand_q;
        dst_d       = dst_q;

        case (state_q)
            ST_READ: begin
                if (rd_fire) begin
                    operand_d   = rd_word;
                    last_port_d = rd_idx;
                    state_d     = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready && !in_valid) state_d = ST_EMPTY;
            end
            default: ;
        endcase

        // Accept overrides the FULL drain so back-to-back bundles have no bubble.
        if (accept) begin
            pc_d      = f_op;
            alu_d     = dec_alu(f_op);
            regs_d    = dec_regs(f_op);
            out_mux_d = (f_op == OP_MOV);
            dst_d     = f_dst;
            src_d     = src_is_port ? f_src : SRC_NIL;
            if (src_is_port) begin
                in_mux_d  = IN_DIR;
                operand_d = '0;
                state_d   = ST_READ;
            end else if (src_is_nil) begin
                in_mux_d  = IN_CONST;
                operand_d = f_const;
                state_d   = ST_FULL;
            end else begin
                in_mux_d  = IN_ACC;
                operand_d = '0;
                state_d   = ST_FULL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            src_q       <= SRC_NIL;
            last_port_q <= 2'd0;
            pc_q        <= '0;
            alu_q       <= '0;
            regs_q      <= '0;
            in_mux_q    <= '0;
            out_mux_q   <= 1'b0;
            operand_q   <= '0;
            dst_q       <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            last_port_q <= last_port_d;
            pc_q        <= pc_d;
            alu_q       <= alu_d;
            regs_q      <= regs_d;
            in_mux_q    <= in_mux_d;
            out_mux_q   <= out_mux_d;
            operand_q   <= operand_d;
            dst_q       <= dst_d;
        end
    end

    assign out_valid       = (state_q == ST_FULL);
    assign pc_instr        = pc_q;
    assign alu_instr       = alu_q;
    assign registers_instr = regs_q;
    assign in_mux_sel      = in_mux_q;
    assign out_mux_sel     = out_mux_q;
    assign operand         = operand_q;
    assign dst             = dst_q;

endmodule
